// File: rtl/prefetch_fetch_stage_pkg.sv
// Shared types for the prefetching fetch stage: machine word, redirect enables,
// and the queue entry carried toward decode.
package prefetch_fetch_stage_pkg;

    typedef logic [31:0] word;

    typedef enum logic {BRANCH_DISABLE = 1'b0, BRANCH_ENABLE = 1'b1} branch_en_t;
    typedef enum logic {JAL_DISABLE    = 1'b0, JAL_ENABLE    = 1'b1} jal_op_t;
    typedef enum logic {JALR_DISABLE   = 1'b0, JALR_ENABLE   = 1'b1} jalr_op_t;

    typedef struct packed {
        word pc;
        word inst;
    } fetch_entry_t;

    localparam word PC_STEP = 32'd4;

    // Sequential successor address, wrapping at 32 bits.
    function automatic word next_pc(input word pc_in);
        return pc_in + PC_STEP;
    endfunction

endpackage

// File: rtl/prefetch_fetch_stage_if.sv
// Instruction-memory request/response channel and decode-side handshake.
interface prefetch_fetch_stage_if;
    import prefetch_fetch_stage_pkg::*;

    logic imem_req_valid;
    logic imem_req_ready;
    word  imem_req_addr;
    logic imem_resp_valid;
    word  imem_resp_data;
    logic inst_valid;
    logic inst_ready;
    word  instruction_out;
    word  pc;
    word  pc_4;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, instruction_out, pc, pc_4,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, instruction_out, pc, pc_4,
        output imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready
    );

endinterface

// File: rtl/prefetch_fetch_stage_fetch_queue.sv
// Synchronous FIFO of fetched {pc, instruction} entries; flush wins over push/pop.
module prefetch_fetch_stage_fetch_queue
    import prefetch_fetch_stage_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push,
    input  fetch_entry_t       push_entry,
    input  logic               pop,
    input  logic               flush,
    output logic               full,
    output logic               empty,
    output logic [CNT_W-1:0]   count,
    output fetch_entry_t       head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t         mem_r [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [CNT_W-1:0]     count_r;
    logic                 do_push_s;
    logic                 do_pop_s;

    // Overflow and underflow attempts are ignored rather than corrupting state.
    always_comb begin
        do_push_s = push && (count_r != CNT_W'(DEPTH));
        do_pop_s  = pop  && (count_r != {CNT_W{1'b0}});
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '{pc: 32'h0000_0000, inst: 32'h0000_0000};
            end
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_entry;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            count_r <= count_r + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
        end
    end

    assign full  = (count_r == CNT_W'(DEPTH));
    assign empty = (count_r == {CNT_W{1'b0}});
    assign count = count_r;
    assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/prefetch_fetch_stage.sv
// Prefetching fetch stage: issues memory requests ahead of decode, buffers
// responses in an in-order queue, and drops stale responses after a redirect.
module prefetch_fetch_stage
    import prefetch_fetch_stage_pkg::*;
#(
    parameter word RESET_VECTOR    = 32'h0000_0000,
    parameter int  QUEUE_DEPTH     = 4,
    parameter int  MAX_OUTSTANDING = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  branch_en_t              branch_en,
    input  jal_op_t                 jal_en,
    input  jalr_op_t                jalr_en,
    input  word                     jump_address,
    prefetch_fetch_stage_if.master  bus
);

    localparam int IF_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int QC_W = $clog2(QUEUE_DEPTH + 1);

    word             fetch_pc_r;
    word             resp_pc_r;
    logic [IF_W-1:0] inflight_r;
    logic [IF_W-1:0] drop_r;

    logic            redirect_s;
    logic            room_s;
    logic            req_valid_s;
    logic            fire_s;
    logic            resp_track_s;
    logic            keep_s;
    logic            pop_s;
    logic            q_full_s;
    logic            q_empty_s;
    logic [QC_W-1:0] q_count_s;
    fetch_entry_t    q_head_s;
    fetch_entry_t    push_entry_s;

    // Request credit: never ask for more than the queue can absorb once every
    // response that will be kept has landed.
    always_comb begin
        redirect_s   = (branch_en == BRANCH_ENABLE) || (jal_en == JAL_ENABLE) ||
                       (jalr_en == JALR_ENABLE);
        room_s       = (32'(q_count_s) + 32'(inflight_r) - 32'(drop_r)) < 32'(QUEUE_DEPTH);
        req_valid_s  = !reset && !redirect_s && room_s &&
                       (32'(inflight_r) < 32'(MAX_OUTSTANDING));
        fire_s       = req_valid_s && bus.imem_req_ready;
        // Responses with nothing outstanding belong to pre-reset requests.
        resp_track_s = bus.imem_resp_valid && (inflight_r != {IF_W{1'b0}});
        keep_s       = resp_track_s && (drop_r == {IF_W{1'b0}}) && !redirect_s;
        pop_s        = !q_empty_s && bus.inst_ready;
        push_entry_s = '{pc: resp_pc_r, inst: bus.imem_resp_data};
    end

    // Fetch/response PC tracking and outstanding-request bookkeeping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc_r <= RESET_VECTOR;
            resp_pc_r  <= RESET_VECTOR;
            inflight_r <= {IF_W{1'b0}};
            drop_r     <= {IF_W{1'b0}};
        end else begin
            inflight_r <= inflight_r + IF_W'(fire_s) - IF_W'(resp_track_s);
            if (redirect_s) begin
                fetch_pc_r <= jump_address;
                resp_pc_r  <= jump_address;
                drop_r     <= inflight_r - IF_W'(resp_track_s);
            end else begin
                if (fire_s) begin
                    fetch_pc_r <= next_pc(fetch_pc_r);
                end
                if (keep_s) begin
                    resp_pc_r <= next_pc(resp_pc_r);
                end
                if (resp_track_s && (drop_r != {IF_W{1'b0}})) begin
                    drop_r <= drop_r - IF_W'(1'b1);
                end
            end
        end
    end

    prefetch_fetch_stage_fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .CNT_W (QC_W)
    ) u_fetch_queue (
        .clock      (clock),
        .reset      (reset),
        .push       (keep_s && !q_full_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .flush      (redirect_s),
        .full       (q_full_s),
        .empty      (q_empty_s),
        .count      (q_count_s),
        .head       (q_head_s)
    );

    assign bus.imem_req_valid  = req_valid_s;
    assign bus.imem_req_addr   = fetch_pc_r;
    assign bus.inst_valid      = !q_empty_s;
    assign bus.instruction_out = q_empty_s ? 32'h0000_0000 : q_head_s.inst;
    assign bus.pc              = q_empty_s ? 32'h0000_0000 : q_head_s.pc;
    assign bus.pc_4            = q_empty_s ? 32'h0000_0000 : next_pc(q_head_s.pc);

endmodule

// File: tb/tb_prefetch_fetch_stage.sv
// Directed bench for prefetch_fetch_stage: per-cycle vector table for the
// ideal-memory / backpressure / stall flow, plus redirect and wrap sequences.
module tb_prefetch_fetch_stage;
    import prefetch_fetch_stage_pkg::*;

    logic       clock;
    logic       reset;
    branch_en_t branch_en;
    jal_op_t    jal_en;
    jalr_op_t   jalr_en;
    word        jump_address;

    prefetch_fetch_stage_if bif();

    prefetch_fetch_stage #(
        .RESET_VECTOR    (32'h0000_0000),
        .QUEUE_DEPTH     (4),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .branch_en    (branch_en),
        .jal_en       (jal_en),
        .jalr_en      (jalr_en),
        .jump_address (jump_address),
        .bus          (bif)
    );

    typedef struct {
        logic ir;      // inst_ready
        logic rr;      // imem_req_ready
        logic exp_rv;  // expected imem_req_valid
        word  exp_ra;  // expected imem_req_addr
        logic exp_iv;  // expected inst_valid
        word  exp_pc;  // expected head pc (when valid)
    } vec_t;

    typedef struct {
        word addr;
        int  due;
    } mem_req_t;

    vec_t     tbl [30];
    mem_req_t pending [$];
    mem_req_t neg_req;
    int       cyc;
    int       mem_lat;
    int       checks;
    int       failures;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Distinct, address-derived instruction word returned by the memory model.
    function automatic word mem_data(input word a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic vec_t mk(input logic ir, input logic rr, input logic rv,
                                input word ra, input logic iv, input word pcv);
        vec_t v;
        v.ir = ir; v.rr = rr; v.exp_rv = rv; v.exp_ra = ra; v.exp_iv = iv; v.exp_pc = pcv;
        return v;
    endfunction

    // Fixed-latency in-order memory: accept at mid-cycle, answer mem_lat cycles later.
    always @(negedge clock) begin
        if (!reset && bif.imem_req_valid && bif.imem_req_ready) begin
            neg_req.addr = bif.imem_req_addr;
            neg_req.due  = cyc + mem_lat;
            pending.push_back(neg_req);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
        cyc = cyc + 1;
        if (pending.size() > 0 && pending[0].due == cyc) begin
            bif.imem_resp_valid = 1'b1;
            bif.imem_resp_data  = mem_data(pending[0].addr);
            pending.delete(0);
        end else begin
            bif.imem_resp_valid = 1'b0;
            bif.imem_resp_data  = 32'h0000_0000;
        end
    endtask

    task automatic chk(input string nm, input word act, input word exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic exp_iv, input word exp_pc);
        word exp_pc4;
        exp_pc4 = exp_pc + 32'd4;
        chk({tag, "_iv"}, 32'(bif.inst_valid), 32'(exp_iv));
        if (exp_iv) begin
            chk({tag, "_pc"},   bif.pc,              exp_pc);
            chk({tag, "_inst"}, bif.instruction_out, mem_data(exp_pc));
            chk({tag, "_pc4"},  bif.pc_4,            exp_pc4);
        end
    endtask

    task automatic check_req(input string tag, input logic exp_rv, input word exp_ra);
        chk({tag, "_rv"}, 32'(bif.imem_req_valid), 32'(exp_rv));
        chk({tag, "_ra"}, bif.imem_req_addr, exp_ra);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_rv"},   32'(bif.imem_req_valid), 32'd0);
        chk({tag, "_ra"},   bif.imem_req_addr,       32'h0000_0000);
        chk({tag, "_iv"},   32'(bif.inst_valid),     32'd0);
        chk({tag, "_inst"}, bif.instruction_out,     32'h0000_0000);
        chk({tag, "_pc"},   bif.pc,                  32'h0000_0000);
        chk({tag, "_pc4"},  bif.pc_4,                32'h0000_0000);
    endtask

    // Assert reset, check reset values before and after a clock edge, release.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        pending.delete();
        bif.imem_resp_valid = 1'b0;
        bif.imem_resp_data  = 32'h0000_0000;
        bif.imem_req_ready  = 1'b1;
        bif.inst_ready      = 1'b1;
        branch_en = BRANCH_DISABLE;
        jal_en    = JAL_DISABLE;
        jalr_en   = JALR_DISABLE;
        #1;
        check_reset_state({tag, "_a"});
        step();
        check_reset_state({tag, "_b"});
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks       = 0;
        failures     = 0;
        cyc          = 0;
        mem_lat      = 1;
        jump_address = 32'h0000_0000;

        // Ideal memory, then 10 cycles of decode backpressure, then a 5-cycle memory stall.
        tbl[0]  = mk(1'b1, 1'b1, 1'b1, 32'd0,  1'b0, 32'd0);
        tbl[1]  = mk(1'b1, 1'b1, 1'b1, 32'd4,  1'b0, 32'd0);
        tbl[2]  = mk(1'b1, 1'b1, 1'b1, 32'd8,  1'b1, 32'd0);
        tbl[3]  = mk(1'b1, 1'b1, 1'b1, 32'd12, 1'b1, 32'd4);
        tbl[4]  = mk(1'b1, 1'b1, 1'b1, 32'd16, 1'b1, 32'd8);
        tbl[5]  = mk(1'b1, 1'b1, 1'b1, 32'd20, 1'b1, 32'd12);
        tbl[6]  = mk(1'b0, 1'b1, 1'b1, 32'd24, 1'b1, 32'd16);
        tbl[7]  = mk(1'b0, 1'b1, 1'b1, 32'd28, 1'b1, 32'd16);
        for (int i = 8; i < 16; i++) begin
            tbl[i] = mk(1'b0, 1'b1, 1'b0, 32'd32, 1'b1, 32'd16);
        end
        tbl[16] = mk(1'b1, 1'b1, 1'b0, 32'd32, 1'b1, 32'd16);
        tbl[17] = mk(1'b1, 1'b1, 1'b1, 32'd32, 1'b1, 32'd20);
        tbl[18] = mk(1'b1, 1'b1, 1'b1, 32'd36, 1'b1, 32'd24);
        tbl[19] = mk(1'b1, 1'b1, 1'b1, 32'd40, 1'b1, 32'd28);
        tbl[20] = mk(1'b1, 1'b1, 1'b1, 32'd44, 1'b1, 32'd32);
        tbl[21] = mk(1'b1, 1'b1, 1'b1, 32'd48, 1'b1, 32'd36);
        tbl[22] = mk(1'b1, 1'b0, 1'b1, 32'd52, 1'b1, 32'd40);
        tbl[23] = mk(1'b1, 1'b0, 1'b1, 32'd52, 1'b1, 32'd44);
        tbl[24] = mk(1'b1, 1'b0, 1'b1, 32'd52, 1'b1, 32'd48);
        tbl[25] = mk(1'b1, 1'b0, 1'b1, 32'd52, 1'b0, 32'd0);
        tbl[26] = mk(1'b1, 1'b0, 1'b1, 32'd52, 1'b0, 32'd0);
        tbl[27] = mk(1'b1, 1'b1, 1'b1, 32'd52, 1'b0, 32'd0);
        tbl[28] = mk(1'b1, 1'b1, 1'b1, 32'd56, 1'b0, 32'd0);
        tbl[29] = mk(1'b1, 1'b1, 1'b1, 32'd60, 1'b1, 32'd52);

        do_reset("rst0");
        for (int i = 0; i < 30; i++) begin
            bif.inst_ready     = tbl[i].ir;
            bif.imem_req_ready = tbl[i].rr;
            #1;
            check_req($sformatf("t%0d", i), tbl[i].exp_rv, tbl[i].exp_ra);
            check_head($sformatf("t%0d", i), tbl[i].exp_iv, tbl[i].exp_pc);
            step();
        end

        // Reset while the queue holds entries and requests are in flight.
        do_reset("rst_mid");

        // JAL with two requests outstanding on a 3-cycle memory.
        mem_lat = 3;
        #1; check_req("ja0", 1'b1, 32'h0000_0000); step();
        #1; check_req("ja1", 1'b1, 32'h0000_0004); step();
        jal_en = JAL_ENABLE; jump_address = 32'h0000_0100;
        #1; chk("ja2_rv", 32'(bif.imem_req_valid), 32'd0); step();
        jal_en = JAL_DISABLE;
        #1; check_req("ja3", 1'b0, 32'h0000_0100); check_head("ja3", 1'b0, 32'd0); step();
        #1; check_req("ja4", 1'b1, 32'h0000_0100); check_head("ja4", 1'b0, 32'd0); step();
        begin
            int  waited;
            logic seen;
            waited = 0;
            seen   = 1'b0;
            while (!seen && waited < 20) begin
                #1;
                if (bif.inst_valid) begin
                    seen = 1'b1;
                end else begin
                    step();
                    waited = waited + 1;
                end
            end
            chk("ja_seen", 32'(seen), 32'd1);
            check_head("ja_first", 1'b1, 32'h0000_0100);
            step();
            #1;
            check_head("ja_second", 1'b1, 32'h0000_0104);
        end

        // Branch in the same cycle as a response, with a partly filled queue.
        do_reset("rst_b");
        mem_lat = 1;
        bif.inst_ready = 1'b0;
        #1; check_req("br0", 1'b1, 32'h0000_0000); step();
        #1; check_req("br1", 1'b1, 32'h0000_0004); step();
        #1; check_req("br2", 1'b1, 32'h0000_0008); check_head("br2", 1'b1, 32'h0000_0000); step();
        branch_en = BRANCH_ENABLE; jump_address = 32'h0000_0200;
        #1; chk("br3_rv", 32'(bif.imem_req_valid), 32'd0); step();
        branch_en = BRANCH_DISABLE;
        bif.inst_ready = 1'b1;
        #1; check_head("br4", 1'b0, 32'd0); check_req("br4", 1'b1, 32'h0000_0200); step();
        #1; check_head("br5", 1'b0, 32'd0); step();
        #1; check_head("br6", 1'b1, 32'h0000_0200); step();

        // JALR to the last word of the address space: PC wraps to zero.
        do_reset("rst_w");
        jalr_en = JALR_ENABLE; jump_address = 32'hFFFF_FFFC;
        #1; chk("wr0_rv", 32'(bif.imem_req_valid), 32'd0); step();
        jalr_en = JALR_DISABLE;
        #1; check_req("wr1", 1'b1, 32'hFFFF_FFFC); step();
        #1; check_req("wr2", 1'b1, 32'h0000_0000); step();
        #1; check_head("wr3", 1'b1, 32'hFFFF_FFFC); chk("wr3_pc4_zero", bif.pc_4, 32'h0000_0000); step();
        #1; check_head("wr4", 1'b1, 32'h0000_0000); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prefetch_fetch_stage.md
# prefetch_fetch_stage

- Parametrised successor to the single-cycle fetch stage.
- Decouples PC generation from decode with:
  - a valid/ready instruction memory request port;
  - in-order responses with variable latency;
  - a QUEUE_DEPTH-entry instruction queue toward decode.
- Redirects from branch/JAL/JALR flush the queue, discard stale in-flight responses and restart at the jump target.
- Sits between the instruction memory and the decode stage.

## Interface
Parameters:
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset
- QUEUE_DEPTH, 4, instruction queue entries (power of two, ≥2)
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered memory requests (≥1)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- branch_en  in  branch_en_t  redirect when BRANCH_ENABLE
- jal_en  in  jal_op_t  redirect when JAL_ENABLE
- jalr_en  in  jalr_op_t  redirect when JALR_ENABLE
- jump_address  in  word  redirect target
- imem_req_valid  out  1  request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  word  request address
- imem_resp_valid  in  1  response valid (no backpressure, in order)
- imem_resp_data  in  word  response instruction
- inst_valid  out  1  queue head valid
- inst_ready  in  1  decode consumes head
- instruction_out  out  word  head instruction
- pc  out  word  head PC
- pc_4  out  word  head PC + 4

## Operation
- **Redirect** = any of the three enables asserted in a cycle.
- **Fetch PC register**
  - Reset to RESET_VECTOR.
  - Advances by 4 on each request fire (valid&&ready).
  - On redirect: loads jump_address. Redirect has priority over the +4.
- **imem_req_valid** asserts when all hold:
  - not redirect;
  - inflight < MAX_OUTSTANDING;
  - queue_count + (inflight − drop) < QUEUE_DEPTH.
  - This credit rule guarantees every kept response has a queue slot.
- **imem_req_addr** = fetch PC.
- **Counters**
  - inflight: +1 on request fire, −1 on response.
  - drop: on response with drop>0, decrement drop and discard the data.
  - Otherwise the response is pushed as {resp_pc, imem_resp_data}, and resp_pc advances by 4.
- **On redirect:**
  - queue cleared;
  - drop ← inflight − imem_resp_valid (any same-cycle response is discarded);
  - resp_pc ← jump_address;
  - inflight updated normally.
- **Decode side**
  - Head popped when inst_valid && inst_ready.
  - pc_4 = head pc + 4, 32-bit wrap-around.
- **Queue full/empty**
  - Queue full never coincides with a kept response (credit rule).
  - Push and pop in the same cycle are both honoured.
  - Pop on empty is ignored.

## Timing
- **Reset values:**
  - imem_req_valid 0 while reset asserted;
  - imem_req_addr = RESET_VECTOR;
  - inst_valid 0;
  - instruction_out, pc, pc_4 = 0;
  - inflight, drop, queue count = 0;
  - resp_pc = RESET_VECTOR.
- **Request timing:** a request may fire in the first cycle after reset deassertion.
- **Latency:** no bypass from response to decode. A response in cycle N gives inst_valid in cycle N+1. With a 1-cycle memory, the first instruction is visible 2 cycles after the first request.
- **Redirect timing:** redirect in cycle N means:
  - no request in cycle N;
  - request to jump_address possible in cycle N+1;
  - inst_valid = 0 in cycle N+1.
- **Throughput:** with a 1-cycle memory, MAX_OUTSTANDING ≥ 2 and QUEUE_DEPTH ≥ 2, one instruction per cycle is sustained.
- **Reset mid-operation:** asynchronously clears all state. Responses still arriving for pre-reset requests are not tracked; the memory is reset together with this block.

## Structure
- **params.sv package additions:**
  - fetch_entry_t packed struct {word pc; word inst;}.
  - Counter width is derived in-module via $clog2.
- **Sub-module fetch_queue:**
  - synchronous FIFO of fetch_entry_t;
  - ports push, pop, flush, full, empty, count;
  - flush has priority over push/pop;
  - instantiated once.

## Test plan
- **Reset, ideal memory:** 1-cycle memory, inst_ready=1, RESET_VECTOR=0 → decode sees PCs 0,4,8,12 on consecutive cycles from cycle 2, with matching instructions and pc_4.
- **Backpressure:** inst_ready=0 for 10 cycles → exactly QUEUE_DEPTH entries buffered, imem_req_valid drops to 0. On release, entries drain in order with no loss or duplication.
- **Redirect with in-flight responses:** 3-cycle memory, MAX_OUTSTANDING=2, jal_en=JAL_ENABLE with jump_address=0x100 while 2 requests are outstanding → both stale responses dropped, next decoded PC is 0x100.
- **Same-cycle redirect and response:** branch_en asserted in the same cycle as imem_resp_valid → that response is discarded and the queue is empty next cycle.
- **Memory stall:** imem_req_ready=0 for 5 cycles → imem_req_addr held stable, PC not advanced.
- **Wrap-around:** redirect to 0xFFFF_FFFC → pc_4 reads 0x0000_0000, and the next fetch address is 0x0000_0000.
